// File: rtl/axi_sram_slv_if.sv
// AXI4 slave bus plus SRAM macro pins for axi_sram_slv.
// The slave modport is the RAM endpoint's view; master is the driver side.
interface axi_sram_slv_if #(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int IDW = 8,
   parameter int MW  = 12
);
   // write address channel
   logic [IDW-1:0] awid;
   logic [AW-1:0]  awaddr;
   logic [7:0]     awlen;
   logic [2:0]     awsize;
   logic [1:0]     awburst;
   logic           awvalid;
   logic           awready;
   // write data channel
   logic [DW-1:0]  wdata;
   logic [3:0]     wstrb;
   logic           wlast;
   logic           wvalid;
   logic           wready;
   // write response channel
   logic [IDW-1:0] bid;
   logic [1:0]     bresp;
   logic           bvalid;
   logic           bready;
   // read address channel
   logic [IDW-1:0] arid;
   logic [AW-1:0]  araddr;
   logic [7:0]     arlen;
   logic [2:0]     arsize;
   logic [1:0]     arburst;
   logic           arvalid;
   logic           arready;
   // read data channel
   logic [IDW-1:0] rid;
   logic [DW-1:0]  rdata;
   logic [1:0]     rresp;
   logic           rlast;
   logic           rvalid;
   logic           rready;
   // SRAM macro
   logic           sram_ce;
   logic           sram_we;
   logic [MW-1:0]  sram_addr;
   logic [DW-1:0]  sram_wdata;
   logic [3:0]     sram_be;
   logic [DW-1:0]  sram_rdata;

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      output sram_ce, sram_we, sram_addr, sram_wdata, sram_be,
      input  sram_rdata
   );

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      input  sram_ce, sram_we, sram_addr, sram_wdata, sram_be,
      output sram_rdata
   );
endinterface

// File: rtl/axi_sram_slv.sv
// AXI4 slave onto a single-port synchronous SRAM, one transaction at a time.
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high; a source holds its valid and payload stable until that edge.
module axi_sram_slv #(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int IDW = 8,
   parameter int MW  = 12
) (
   input  logic          clk,
   input  logic          reset,
   axi_sram_slv_if.slave bus,
   output logic [1:0]    o_dbg_state
);
   typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, WRESP = 2'd2, RD = 2'd3} state_t;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] BURST_WRAP = 2'b10;

   state_t         r_state, w_state_nxt;
   logic           r_favor_wr;     // 0: read wins a tie, 1: write wins
   logic [AW-1:0]  r_addr;
   logic [7:0]     r_len;
   logic [7:0]     r_beat;         // beats accepted (write) or issued (read)
   logic [2:0]     r_size;
   logic [1:0]     r_burst;
   logic [IDW-1:0] r_id;
   logic           r_err;
   logic           r_issue_done;
   logic           r_rvalid;
   logic           r_rlast;
   logic [1:0]     r_rresp;
   logic           r_fresh;        // rvalid beat arrived this cycle from the SRAM
   logic [DW-1:0]  r_rdata;

   logic           w_grant_rd, w_grant_wr;
   logic [AW-1:0]  w_sel_addr;
   logic [7:0]     w_sel_len;
   logic [2:0]     w_sel_size;
   logic [1:0]     w_sel_burst;
   logic [IDW-1:0] w_sel_id;
   logic           w_wrap_len_ok, w_hs_err;
   logic [AW-1:0]  w_step, w_wrap_mask, w_next_addr;
   logic           w_step_err, w_wr_beat, w_rd_issue;
   logic [DW-1:0]  w_rdata;
   logic           w_awready, w_arready, w_wready, w_bvalid;
   logic           w_sram_ce, w_sram_we;
   logic [3:0]     w_sram_be;

   // arbitration between the two address channels, only while idle
   assign w_grant_rd = (r_state == IDLE) && bus.arvalid && (!bus.awvalid || !r_favor_wr);
   assign w_grant_wr = (r_state == IDLE) && bus.awvalid && !w_grant_rd;

   assign w_sel_addr  = w_grant_rd ? bus.araddr  : bus.awaddr;
   assign w_sel_len   = w_grant_rd ? bus.arlen   : bus.awlen;
   assign w_sel_size  = w_grant_rd ? bus.arsize  : bus.awsize;
   assign w_sel_burst = w_grant_rd ? bus.arburst : bus.awburst;
   assign w_sel_id    = w_grant_rd ? bus.arid    : bus.awid;

   assign w_wrap_len_ok = (w_sel_len == 8'd1) || (w_sel_len == 8'd3) ||
                          (w_sel_len == 8'd7) || (w_sel_len == 8'd15);
   assign w_hs_err = (w_sel_size > 3'd2) || (|w_sel_addr[AW-1:MW+2]) ||
                     (w_sel_burst == 2'b11) ||
                     ((w_sel_burst == BURST_WRAP) && !w_wrap_len_ok);

   // beat address stepping; WRAP keeps the upper bits and wraps the low ones
   assign w_step      = AW'(1) << r_size;
   assign w_wrap_mask = ((AW'(r_len) + AW'(1)) << r_size) - AW'(1);

   // next beat address for FIXED / INCR / WRAP
   always_comb begin
      w_next_addr = r_addr;
      if (r_burst == BURST_INCR)
         w_next_addr = r_addr + w_step;
      else if (r_burst == BURST_WRAP)
         w_next_addr = (r_addr & ~w_wrap_mask) | ((r_addr + w_step) & w_wrap_mask);
   end

   assign w_step_err = (r_burst == BURST_INCR) && (|w_next_addr[AW-1:MW+2]);
   assign w_wr_beat  = (r_state == WR) && bus.wvalid;
   assign w_rd_issue = (r_state == RD) && !r_issue_done && (!r_rvalid || bus.rready);
   // a fresh beat comes straight from the macro; a stalled one from the capture
   assign w_rdata    = r_rresp[1] ? '0 : (r_fresh ? bus.sram_rdata : r_rdata);

   // state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // next state and channel/SRAM strobes
   always_comb begin
      w_state_nxt = r_state;
      w_awready   = 1'b0;
      w_arready   = 1'b0;
      w_wready    = 1'b0;
      w_bvalid    = 1'b0;
      w_sram_ce   = 1'b0;
      w_sram_we   = 1'b0;
      w_sram_be   = 4'h0;
      case (r_state)
         IDLE: begin
            w_arready = w_grant_rd;
            w_awready = w_grant_wr;
            if (w_grant_rd)      w_state_nxt = RD;
            else if (w_grant_wr) w_state_nxt = WR;
         end
         WR: begin
            w_wready = 1'b1;
            if (bus.wvalid) begin
               if (!r_err) begin
                  w_sram_ce = 1'b1;
                  w_sram_we = 1'b1;
                  w_sram_be = bus.wstrb;
               end
               if (bus.wlast) w_state_nxt = WRESP;
            end
         end
         WRESP: begin
            w_bvalid = 1'b1;
            if (bus.bready) w_state_nxt = IDLE;
         end
         RD: begin
            if (w_rd_issue && !r_err) w_sram_ce = 1'b1;
            if (r_rvalid && bus.rready && r_rlast) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // transaction context, beat bookkeeping and read output pipeline
   always_ff @(posedge clk) begin
      if (reset) begin
         r_favor_wr   <= 1'b0;
         r_addr       <= '0;
         r_len        <= '0;
         r_beat       <= '0;
         r_size       <= '0;
         r_burst      <= '0;
         r_id         <= '0;
         r_err        <= 1'b0;
         r_issue_done <= 1'b0;
         r_rvalid     <= 1'b0;
         r_rlast      <= 1'b0;
         r_rresp      <= 2'b00;
         r_fresh      <= 1'b0;
         r_rdata      <= '0;
      end else begin
         if (w_grant_rd || w_grant_wr) begin
            r_favor_wr   <= w_grant_rd;
            r_addr       <= w_sel_addr;
            r_len        <= w_sel_len;
            r_size       <= w_sel_size;
            r_burst      <= w_sel_burst;
            r_id         <= w_sel_id;
            r_err        <= w_hs_err;
            r_beat       <= '0;
            r_issue_done <= 1'b0;
         end
         if (w_wr_beat) begin
            r_beat <= r_beat + 8'd1;
            r_addr <= w_next_addr;
            // early wlast, missing wlast at len, or running off the end
            if (w_step_err || (bus.wlast != (r_beat == r_len))) r_err <= 1'b1;
         end
         if (w_rd_issue) begin
            r_beat       <= r_beat + 8'd1;
            r_addr       <= w_next_addr;
            r_issue_done <= (r_beat == r_len);
            if (w_step_err) r_err <= 1'b1;
            r_rvalid     <= 1'b1;
            r_rlast      <= (r_beat == r_len);
            r_rresp      <= r_err ? 2'b10 : 2'b00;
         end else if (r_rvalid && bus.rready) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rresp  <= 2'b00;
         end
         r_fresh <= w_rd_issue;
         if (r_fresh) r_rdata <= w_rdata;
      end
   end

   assign bus.awready    = w_awready;
   assign bus.arready    = w_arready;
   assign bus.wready     = w_wready;
   assign bus.bvalid     = w_bvalid;
   assign bus.bid        = r_id;
   assign bus.bresp      = (r_state == WRESP && r_err) ? 2'b10 : 2'b00;
   assign bus.rid        = r_id;
   assign bus.rdata      = w_rdata;
   assign bus.rresp      = r_rresp;
   assign bus.rlast      = r_rlast;
   assign bus.rvalid     = r_rvalid;
   assign bus.sram_ce    = w_sram_ce;
   assign bus.sram_we    = w_sram_we;
   assign bus.sram_addr  = r_addr[MW+1:2];
   assign bus.sram_wdata = bus.wdata;
   assign bus.sram_be    = w_sram_be;
   assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_axi_sram_slv.sv
// Directed bench for axi_sram_slv with a behavioural SRAM macro behind it.
module tb_axi_sram_slv;
   logic        clk;
   logic        reset;
   logic [1:0]  dbg_state;
   logic [31:0] mem [0:4095];
   logic [31:0] sram_q;
   logic [31:0] wr_data [0:3];
   logic [31:0] exp_q [$];
   int          n_total;
   int          n_bad;
   int          ce_cnt;
   int          c0;
   logic        f_wr, s_wr;

   axi_sram_slv_if #(.AW(32), .DW(32), .IDW(8), .MW(12)) bus ();

   axi_sram_slv #(.AW(32), .DW(32), .IDW(8), .MW(12)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM macro model: byte-enabled write, read data one cycle after access
   always @(posedge clk) begin
      if (bus.sram_ce) begin
         if (bus.sram_we) begin
            for (int i = 0; i < 4; i++)
               if (bus.sram_be[i]) mem[bus.sram_addr][i*8 +: 8] <= bus.sram_wdata[i*8 +: 8];
         end else begin
            sram_q <= mem[bus.sram_addr];
         end
      end
   end
   assign bus.sram_rdata = sram_q;

   always @(posedge clk) if (bus.sram_ce) ce_cnt <= ce_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int last_at,
                           input logic [1:0] exp_resp);
      int t;
      @(negedge clk);
      bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
      bus.awvalid = 1'b1;
      t = 0;
      #1;
      while (!bus.awready && t < 50) begin @(negedge clk); #1; t++; end
      chk("aw_grant", 32'(t < 50), 32'd1);
      @(negedge clk);
      bus.awvalid = 1'b0;
      #1;
      chk("wready_c1", 32'(bus.wready), 32'd1);
      for (int b = 0; b <= last_at; b++) begin
         bus.wdata = wr_data[b % 4]; bus.wstrb = 4'hF; bus.wlast = (b == last_at); bus.wvalid = 1'b1;
         @(negedge clk);
      end
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
      #1;
      chk("bvalid_lat", 32'(bus.bvalid), 32'd1);
      chk("bresp", 32'(bus.bresp), 32'(exp_resp));
      chk("bid", 32'(bus.bid), 32'(id));
      bus.bready = 1'b1;
      @(negedge clk);
      bus.bready = 1'b0;
      #1;
      chk("wr_idle", 32'(dbg_state), 32'd0);
   endtask

   task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic stall,
                          input logic [1:0] exp_resp);
      int t, beats;
      logic prev_stall, p_last;
      logic [31:0] p_data, exp;
      @(negedge clk);
      bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
      bus.arvalid = 1'b1;
      #1;
      chk("ar_grant", 32'(bus.arready), 32'd1);
      chk("aw_quiet", 32'(bus.awready), 32'd0);
      @(negedge clk);
      bus.arvalid = 1'b0;
      beats = 0; t = 0; prev_stall = 1'b0; p_data = '0; p_last = 1'b0;
      while (beats <= int'(len) && t < 2000) begin
         bus.rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (!stall && t == 0) chk("rvalid_c1", 32'(bus.rvalid), 32'd0);
         if (!stall && t >= 1) chk("rvalid_run", 32'(bus.rvalid), 32'd1);
         if (prev_stall) begin
            chk("hold_valid", 32'(bus.rvalid), 32'd1);
            chk("hold_data", bus.rdata, p_data);
            chk("hold_last", 32'(bus.rlast), 32'(p_last));
         end
         prev_stall = bus.rvalid && !bus.rready;
         p_data = bus.rdata; p_last = bus.rlast;
         if (bus.rvalid && bus.rready) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            chk("rdata", bus.rdata, exp);
            chk("rresp", 32'(bus.rresp), 32'(exp_resp));
            chk("rlast", 32'(bus.rlast), 32'(beats == int'(len)));
            chk("rid", 32'(bus.rid), 32'(id));
            beats++;
         end
         @(negedge clk);
         t++;
      end
      if (t >= 2000) chk("rd_timeout", 32'd0, 32'd1);
      bus.rready = 1'b0;
      #1;
      chk("rd_idle", 32'(dbg_state), 32'd0);
      chk("rd_rvalid_low", 32'(bus.rvalid), 32'd0);
   endtask

   // simultaneous/single requests with len=0; reports grant order (0=read, 1=write)
   task automatic arb_run(input logic do_ar, input logic do_aw, output logic first_wr,
                          output logic second_wr);
      int t, g;
      logic r_done, b_done, hs_ar, hs_aw, hs_w;
      logic [1:0] order;
      order = 2'b00; g = 0; t = 0;
      r_done = !do_ar; b_done = !do_aw;
      @(negedge clk);
      bus.arid = 8'h21; bus.araddr = 32'h40; bus.arlen = 8'd0; bus.arsize = 3'd2; bus.arburst = 2'b01;
      bus.awid = 8'h22; bus.awaddr = 32'h60; bus.awlen = 8'd0; bus.awsize = 3'd2; bus.awburst = 2'b01;
      bus.wdata = 32'hA5A5_0001; bus.wstrb = 4'hF; bus.wlast = do_aw; bus.wvalid = do_aw;
      bus.arvalid = do_ar; bus.awvalid = do_aw; bus.rready = 1'b1; bus.bready = 1'b1;
      while ((!r_done || !b_done) && t < 60) begin
         #1;
         hs_ar = bus.arvalid && bus.arready;
         hs_aw = bus.awvalid && bus.awready;
         hs_w  = bus.wvalid && bus.wready;
         if (hs_ar && g < 2) begin order[g] = 1'b0; g++; end
         if (hs_aw && g < 2) begin order[g] = 1'b1; g++; end
         if (bus.rvalid && bus.rready) begin
            chk("arb_rdata", bus.rdata, 32'h11);
            if (bus.rlast) r_done = 1'b1;
         end
         if (bus.bvalid && bus.bready) b_done = 1'b1;
         @(negedge clk);
         t++;
         if (hs_ar) bus.arvalid = 1'b0;
         if (hs_aw) bus.awvalid = 1'b0;
         if (hs_w) begin bus.wvalid = 1'b0; bus.wlast = 1'b0; end
      end
      if (t >= 60) chk("arb_timeout", 32'd0, 32'd1);
      bus.rready = 1'b0; bus.bready = 1'b0;
      first_wr = order[0]; second_wr = order[1];
   endtask

   // reset and directed sequence
   initial begin
      n_total = 0; n_bad = 0; ce_cnt = 0;
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_state", 32'(dbg_state), 32'd0);
      chk("rst_arready", 32'(bus.arready), 32'd0);
      chk("rst_awready", 32'(bus.awready), 32'd0);
      chk("rst_wready", 32'(bus.wready), 32'd0);
      chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
      chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
      chk("rst_rlast", 32'(bus.rlast), 32'd0);
      chk("rst_ce", 32'(bus.sram_ce), 32'd0);
      chk("rst_resp", 32'({bus.bresp, bus.rresp}), 32'd0);
      reset = 1'b0;

      // INCR write of four words at 0x40
      wr_data[0] = 32'h11; wr_data[1] = 32'h22; wr_data[2] = 32'h33; wr_data[3] = 32'h44;
      c0 = ce_cnt;
      do_write(8'h5A, 32'h40, 8'd3, 3'd2, 2'b01, 3, 2'b00);
      chk("wr_ce_cnt", 32'(ce_cnt - c0), 32'd4);
      chk("mem_10", mem[12'h10], 32'h11);
      chk("mem_11", mem[12'h11], 32'h22);
      chk("mem_12", mem[12'h12], 32'h33);
      chk("mem_13", mem[12'h13], 32'h44);

      // INCR read back, no stalls
      exp_q.push_back(32'h11); exp_q.push_back(32'h22); exp_q.push_back(32'h33); exp_q.push_back(32'h44);
      do_read(8'h33, 32'h40, 8'd3, 3'd2, 2'b01, 1'b0, 2'b00);

      // WRAP read from 0x48 visits words 0x12, 0x13, 0x10, 0x11, with random stalls
      exp_q.push_back(32'h33); exp_q.push_back(32'h44); exp_q.push_back(32'h11); exp_q.push_back(32'h22);
      do_read(8'h34, 32'h48, 8'd3, 3'd2, 2'b10, 1'b1, 2'b00);

      // errored writes: bad size, out-of-range address
      c0 = ce_cnt;
      do_write(8'h41, 32'h40, 8'd3, 3'd3, 2'b01, 3, 2'b10);
      do_write(8'h42, 32'h0001_0000, 8'd3, 3'd2, 2'b01, 3, 2'b10);
      chk("err_wr_no_ce", 32'(ce_cnt - c0), 32'd0);
      chk("err_wr_mem_kept", mem[12'h10], 32'h11);

      // errored reads return zero data with SLVERR on every beat
      c0 = ce_cnt;
      repeat (4) exp_q.push_back(32'h0);
      do_read(8'h43, 32'h40, 8'd3, 3'd3, 2'b01, 1'b0, 2'b10);
      repeat (2) exp_q.push_back(32'h0);
      do_read(8'h44, 32'h0001_0000, 8'd1, 3'd2, 2'b01, 1'b0, 2'b10);
      chk("err_rd_no_ce", 32'(ce_cnt - c0), 32'd0);

      // arbitration: read wins the first tie after reset, then the pointer alternates
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      arb_run(1'b1, 1'b1, f_wr, s_wr);
      chk("arb1_first", 32'(f_wr), 32'd0);
      chk("arb1_second", 32'(s_wr), 32'd1);
      chk("arb_wr_mem", mem[12'h18], 32'hA5A5_0001);
      arb_run(1'b1, 1'b0, f_wr, s_wr);
      chk("arb2_first", 32'(f_wr), 32'd0);
      arb_run(1'b1, 1'b1, f_wr, s_wr);
      chk("arb3_first", 32'(f_wr), 32'd1);
      chk("arb3_second", 32'(s_wr), 32'd0);

      // early wlast at beat 1 of a 4-beat burst
      do_write(8'h66, 32'h100, 8'd3, 3'd2, 2'b01, 1, 2'b10);

      // reset in the middle of a read burst
      @(negedge clk);
      bus.arid = 8'h70; bus.araddr = 32'h40; bus.arlen = 8'd7; bus.arsize = 3'd2; bus.arburst = 2'b01;
      bus.arvalid = 1'b1;
      #1;
      chk("mid_ar_grant", 32'(bus.arready), 32'd1);
      @(negedge clk);
      bus.arvalid = 1'b0; bus.rready = 1'b0;
      @(negedge clk);
      #1;
      chk("mid_rvalid_pre", 32'(bus.rvalid), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      #1;
      chk("mid_rvalid_rst", 32'(bus.rvalid), 32'd0);
      chk("mid_state_rst", 32'(dbg_state), 32'd0);
      chk("mid_ce_rst", 32'(bus.sram_ce), 32'd0);
      reset = 1'b0;
      exp_q.push_back(32'h22);
      do_read(8'h71, 32'h44, 8'd0, 3'd2, 2'b01, 1'b0, 2'b00);

      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // absolute time limit so the run always ends
   initial begin
      #500000;
      $display("FAIL global_timeout: got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
